// File: rtl/jk_bank_arbiter.sv
// Bank of 2**IDX_W JK bits shared by four requesters through a round-robin arbiter.
// One command is applied per cycle; q, gnt and served_cnt are all registered.
module jk_bank_arbiter #(
    parameter int unsigned IDX_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [3:0]             req,
    input  logic [7:0]             op,
    input  logic [4*IDX_W-1:0]     idx,
    output logic [2**IDX_W-1:0]    q,
    output logic [3:0]             gnt,
    output logic [7:0]             served_cnt
);
    localparam int unsigned NREQ = 4;

    logic [1:0]       last_ptr;
    logic [NREQ-1:0]  elig;
    logic             found;
    logic [1:0]       sel;
    logic [1:0]       cand;
    logic [1:0]       op_arr  [NREQ];
    logic [IDX_W-1:0] idx_arr [NREQ];
    logic [1:0]       op_sel;
    logic [IDX_W-1:0] idx_sel;
    logic             bit_next;

    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
        assign op_arr[r]  = op[2*r +: 2];
        assign idx_arr[r] = idx[r*IDX_W +: IDX_W];
    end

    // A requester granted last cycle sits out one cycle to refresh or drop its command.
    assign elig = req & ~gnt;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = last_ptr + 2'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign op_sel  = op_arr[sel];
    assign idx_sel = idx_arr[sel];

    always_comb begin
        case (op_sel)
            2'b10:   bit_next = 1'b1;
            2'b01:   bit_next = 1'b0;
            2'b11:   bit_next = ~q[idx_sel];
            default: bit_next = q[idx_sel];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            gnt        <= '0;
            served_cnt <= '0;
            last_ptr   <= 2'd3;
        end else if (clr) begin
            q   <= '0;
            gnt <= '0;
        end else if (found) begin
            q[idx_sel] <= bit_next;
            gnt        <= 4'b0001 << sel;
            last_ptr   <= sel;
            served_cnt <= served_cnt + 8'd1;
        end else begin
            gnt <= '0;
        end
    end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed-vector bench for jk_bank_arbiter: reset, JK commands, fairness, clear,
// counter wrap and mid-operation reset, all against hand-computed values.
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] idx;
    logic [7:0]  q;
    logic [3:0]  gnt;
    logic [7:0]  served_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.IDX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .req        (req),
        .op         (op),
        .idx        (idx),
        .q          (q),
        .gnt        (gnt),
        .served_cnt (served_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int r, input logic [1:0] jk, input logic [2:0] b);
        op  = (op  & ~(8'h03  << (2*r))) | (8'(jk) << (2*r));
        idx = (idx & ~(12'h007 << (3*r))) | (12'(b) << (3*r));
    endtask

    task automatic do_reset;
        rst = 1'b1; clr = 1'b0; req = '0; op = '0; idx = '0;
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] fair_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] fair_q   [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};

    initial begin
        // Reset with every requester pending
        rst = 1'b1; clr = 1'b0; req = 4'b1111; op = '0; idx = '0;
        tick();
        check("rst_q",   32'(q),          32'h00);
        check("rst_gnt", 32'(gnt),        32'h0);
        check("rst_cnt", 32'(served_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("first_gnt", 32'(gnt),        32'b0001);
        check("first_cnt", 32'(served_cnt), 32'd1);
        tick();
        check("second_gnt", 32'(gnt), 32'b0010);

        // Set, toggle, reset on bit 5 from requester 2
        do_reset();
        set_cmd(2, 2'b10, 3'd5);
        req = 4'b0100;
        tick();
        check("cmd_set_q",   32'(q),   32'h20);
        check("cmd_set_gnt", 32'(gnt), 32'b0100);
        set_cmd(2, 2'b11, 3'd5);
        tick();
        check("cmd_idle1_gnt", 32'(gnt), 32'b0000);
        check("cmd_idle1_q",   32'(q),   32'h20);
        tick();
        check("cmd_tog_q",   32'(q),   32'h00);
        check("cmd_tog_gnt", 32'(gnt), 32'b0100);
        set_cmd(2, 2'b01, 3'd5);
        tick();
        check("cmd_idle2_gnt", 32'(gnt), 32'b0000);
        tick();
        check("cmd_rst_q",   32'(q),          32'h00);
        check("cmd_rst_gnt", 32'(gnt),        32'b0100);
        check("cmd_cnt",     32'(served_cnt), 32'd3);
        req = '0;

        // Round-robin fairness with toggles on distinct bits
        do_reset();
        op  = 8'hFF;
        idx = {3'd3, 3'd2, 3'd1, 3'd0};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fair_gnt%0d", i), 32'(gnt), 32'(fair_gnt[i]));
            check($sformatf("fair_q%0d", i),   32'(q),   32'(fair_q[i]));
            if (i == 3) check("fair_cnt4", 32'(served_cnt), 32'd4);
        end
        req = '0;

        // Clear with a pending requester
        do_reset();
        set_cmd(0, 2'b10, 3'd4);
        req = 4'b0001;
        tick();
        check("clr_pre_q", 32'(q), 32'h10);
        req = '0;
        tick();
        check("clr_gap_gnt", 32'(gnt), 32'b0000);
        set_cmd(0, 2'b11, 3'd4);
        req = 4'b0001;
        clr = 1'b1;
        tick();
        check("clr_q",   32'(q),          32'h00);
        check("clr_gnt", 32'(gnt),        32'b0000);
        check("clr_cnt", 32'(served_cnt), 32'd1);
        clr = 1'b0;
        tick();
        check("clr_post_q",   32'(q),          32'h10);
        check("clr_post_gnt", 32'(gnt),        32'b0001);
        check("clr_post_cnt", 32'(served_cnt), 32'd2);
        req = '0;

        // served_cnt wrap: one set, then 256 hold commands alternating two requesters
        do_reset();
        set_cmd(1, 2'b10, 3'd6);
        req = 4'b0010;
        tick();
        check("wrap_set_q",   32'(q),          32'h40);
        check("wrap_set_cnt", 32'(served_cnt), 32'd1);
        op  = '0;
        req = 4'b0011;
        repeat (255) tick();
        check("wrap_cnt0", 32'(served_cnt), 32'd0);
        check("wrap_q0",   32'(q),          32'h40);
        tick();
        check("wrap_cnt1", 32'(served_cnt), 32'd1);
        check("wrap_q1",   32'(q),          32'h40);
        req = '0;

        // Reset coinciding with an eligible set on bit 7; arbitration restarts at 0
        do_reset();
        req = 4'b0001;
        tick();
        check("mid_pre_gnt", 32'(gnt), 32'b0001);
        set_cmd(3, 2'b10, 3'd7);
        req = 4'b1001;
        rst = 1'b1;
        tick();
        check("mid_q",   32'(q),          32'h00);
        check("mid_gnt", 32'(gnt),        32'b0000);
        check("mid_cnt", 32'(served_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_first_gnt", 32'(gnt), 32'b0001);
        check("mid_first_q",   32'(q),   32'h00);
        tick();
        check("mid_retry_gnt", 32'(gnt),        32'b1000);
        check("mid_retry_q",   32'(q),          32'h80);
        check("mid_retry_cnt", 32'(served_cnt), 32'd2);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
